decode_issue: RTL and testbench

DECODE_ISSUE -- requirements
Module: decode_issue

---
 rtl/decode_issue.sv | 169 ++++++++++++++++
 tb/tb_decode_issue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// MIPS-subset decoder feeding a 2-entry skid FIFO of decoded ops toward the exec stage.
// in_ready depends only on registered occupancy, so out_ready never reaches it combinationally.
module decode_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        flush,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  rd_addr,
  output logic [31:0] imm,
  output logic [11:0] aluop,
  output logic        alu_src,
  output logic        branch,
  output logic        reg_write,
  output logic        illegal
);

  localparam logic [11:0] AluAdd  = 12'h001;
  localparam logic [11:0] AluSub  = 12'h002;
  localparam logic [11:0] AluAnd  = 12'h004;
  localparam logic [11:0] AluOr   = 12'h008;
  localparam logic [11:0] AluXor  = 12'h010;
  localparam logic [11:0] AluNor  = 12'h020;
  localparam logic [11:0] AluSlt  = 12'h040;
  localparam logic [11:0] AluSltu = 12'h080;
  localparam logic [11:0] AluSll  = 12'h100;
  localparam logic [11:0] AluSrl  = 12'h200;
  localparam logic [11:0] AluSra  = 12'h400;
  localparam logic [11:0] AluLui  = 12'h800;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [11:0] aluop;
    logic        alu_src;
    logic        branch;
    logic        reg_write;
    logic        illegal;
  } op_t;

  op_t         dec;
  logic        legal;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] simm;
  logic [31:0] zimm;

  assign opcode = in_instr[31:26];
  assign funct  = in_instr[5:0];
  assign simm   = {{16{in_instr[15]}}, in_instr[15:0]};
  assign zimm   = {16'b0, in_instr[15:0]};

  always_comb begin
    dec    = '0;
    legal  = 1'b1;
    dec.rs = in_instr[25:21];
    dec.rt = in_instr[20:16];
    case (opcode)
      6'h00: begin
        dec.rd  = in_instr[15:11];
        dec.imm = {27'b0, in_instr[10:6]};
        case (funct)
          6'h20, 6'h21: dec.aluop = AluAdd;
          6'h22, 6'h23: dec.aluop = AluSub;
          6'h24:        dec.aluop = AluAnd;
          6'h25:        dec.aluop = AluOr;
          6'h26:        dec.aluop = AluXor;
          6'h27:        dec.aluop = AluNor;
          6'h2A:        dec.aluop = AluSlt;
          6'h2B:        dec.aluop = AluSltu;
          6'h00:        dec.aluop = AluSll;
          6'h02:        dec.aluop = AluSrl;
          6'h03:        dec.aluop = AluSra;
          default:      legal     = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin dec.aluop = AluAdd;  dec.imm = simm; end
      6'h0A:        begin dec.aluop = AluSlt;  dec.imm = simm; end
      6'h0B:        begin dec.aluop = AluSltu; dec.imm = simm; end
      6'h0C:        begin dec.aluop = AluAnd;  dec.imm = zimm; end
      6'h0D:        begin dec.aluop = AluOr;   dec.imm = zimm; end
      6'h0E:        begin dec.aluop = AluXor;  dec.imm = zimm; end
      6'h0F:        begin dec.aluop = AluLui;  dec.imm = {in_instr[15:0], 16'b0}; end
      6'h04: begin
        dec.branch = 1'b1;
        dec.aluop  = AluSub;
        dec.imm    = simm;
      end
      default: legal = 1'b0;
    endcase
    // I-type ops write rt and take the immediate as operand 2
    if (opcode[5:3] == 3'b001) begin
      dec.rd      = in_instr[20:16];
      dec.alu_src = 1'b1;
    end
    if (!legal) begin
      dec         = '0;
      dec.rs      = in_instr[25:21];
      dec.rt      = in_instr[20:16];
      dec.illegal = 1'b1;
    end
    dec.reg_write = legal && !dec.branch && (dec.rd != 5'd0);
  end

  op_t        mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       accept, consume;
  op_t        head;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (accept)  wr_ptr_d = ~wr_ptr_q;
      if (consume) rd_ptr_d = ~rd_ptr_q;
      case ({accept, consume})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (accept && !flush) mem_q[wr_ptr_q] <= dec;
    end
  end

  assign head      = out_valid ? mem_q[rd_ptr_q] : '0;
  assign rs_addr   = head.rs;
  assign rt_addr   = head.rt;
  assign rd_addr   = head.rd;
  assign imm       = head.imm;
  assign aluop     = head.aluop;
  assign alu_src   = head.alu_src;
  assign branch    = head.branch;
  assign reg_write = head.reg_write;
  assign illegal   = head.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: queue-based FIFO/decode model checked every cycle, plus literal pins.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, flush;
  logic [31:0] in_instr;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [31:0] imm;
  logic [11:0] aluop;
  logic        alu_src, branch, reg_write, illegal;

  int checks = 0;
  int failures = 0;

  decode_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush), .rs_addr(rs_addr),
    .rt_addr(rt_addr), .rd_addr(rd_addr), .imm(imm), .aluop(aluop), .alu_src(alu_src),
    .branch(branch), .reg_write(reg_write), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic [11:0] aluop;
    logic        alu_src, branch, reg_write, illegal;
  } op_t;

  op_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Table-driven reading of the ISA subset: ALU index per opcode/funct, -1 = undecodable.
  function automatic op_t model(input logic [31:0] w);
    op_t o;
    int  idx = -1;
    int  kind = 0;  // 0 R-type, 1 sign-ext I, 2 zero-ext I, 3 LUI, 4 BEQ
    logic [5:0] opc = w[31:26];
    logic [5:0] fn  = w[5:0];
    if (opc == 6'h00) begin
      if (fn == 6'h20 || fn == 6'h21) idx = 0;
      if (fn == 6'h22 || fn == 6'h23) idx = 1;
      if (fn >= 6'h24 && fn <= 6'h27) idx = 2 + int'(fn - 6'h24);
      if (fn == 6'h2A) idx = 6;
      if (fn == 6'h2B) idx = 7;
      if (fn == 6'h00) idx = 8;
      if (fn == 6'h02) idx = 9;
      if (fn == 6'h03) idx = 10;
    end else if (opc == 6'h08 || opc == 6'h09) begin idx = 0;  kind = 1; end
    else if (opc == 6'h0A) begin idx = 6;  kind = 1; end
    else if (opc == 6'h0B) begin idx = 7;  kind = 1; end
    else if (opc == 6'h0C) begin idx = 2;  kind = 2; end
    else if (opc == 6'h0D) begin idx = 3;  kind = 2; end
    else if (opc == 6'h0E) begin idx = 4;  kind = 2; end
    else if (opc == 6'h0F) begin idx = 11; kind = 3; end
    else if (opc == 6'h04) begin idx = 1;  kind = 4; end
    o.rs        = w[25:21];
    o.rt        = w[20:16];
    o.illegal   = (idx < 0);
    o.aluop     = o.illegal ? 12'h000 : 12'(1 << idx);
    o.alu_src   = !o.illegal && (kind >= 1 && kind <= 3);
    o.branch    = !o.illegal && kind == 4;
    o.rd        = (kind == 0) ? w[15:11] : w[20:16];
    case (kind)
      0:       o.imm = 32'(w[10:6]);
      2:       o.imm = 32'(w[15:0]);
      3:       o.imm = {w[15:0], 16'h0000};
      default: o.imm = 32'($signed(w[15:0]));
    endcase
    o.reg_write = !o.illegal && !o.branch && o.rd != 5'd0;
    return o;
  endfunction

  always @(negedge rst_n) q.delete();

  always @(posedge clk) begin
    if (rst_n) begin
      bit acc, con;
      acc = in_valid && q.size() < 2;
      con = out_ready && q.size() > 0;
      if (flush) q.delete();
      else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back(model(in_instr));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("rs_addr", 32'(rs_addr), 32'(q[0].rs));
        chk("rt_addr", 32'(rt_addr), 32'(q[0].rt));
        chk("aluop", 32'(aluop), 32'(q[0].aluop));
        chk("flags", {28'h0, alu_src, branch, reg_write, illegal},
            {28'h0, q[0].alu_src, q[0].branch, q[0].reg_write, q[0].illegal});
        if (!q[0].illegal) chk("imm", imm, q[0].imm);
        if (!q[0].illegal && !q[0].branch) chk("rd_addr", 32'(rd_addr), 32'(q[0].rd));
      end else begin
        chk("idle_zero", 32'({rs_addr, rt_addr, rd_addr, aluop, alu_src, branch, reg_write,
                              illegal} != 0 || imm != 0), 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    in_valid = 1'b1;
    in_instr = w;
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] vecs [8] = '{32'h00221820, 32'h000520C3, 32'h1022FFFF, 32'h0022183F,
                           32'h3441ABCD, 32'h24A2FFF0, 32'h00000000, 32'hFC000000};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
    #2;
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    #10 rst_n = 1'b1;
    step();
    chk("post_reset_in_ready", 32'(in_ready), 32'h1);

    // Single ADDI r9,r0,5
    out_ready = 1'b1;
    send(32'h20090005);
    chk("addi_valid", 32'(out_valid), 32'h1);
    chk("addi_aluop", 32'(aluop), 32'h001);
    chk("addi_alu_src", 32'(alu_src), 32'h1);
    chk("addi_imm", imm, 32'h5);
    chk("addi_rd", 32'(rd_addr), 32'h9);
    chk("addi_reg_write", 32'(reg_write), 32'h1);
    step();

    // Backpressure: three offered, two taken, drained in order
    out_ready = 1'b0;
    send(32'h00221820);
    send(32'h000520C3);
    chk("bp_in_ready_full", 32'(in_ready), 32'h0);
    chk("bp_head_first", 32'(rd_addr), 32'h3);
    send(32'h1022FFFF);
    chk("bp_still_full", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    step();
    chk("bp_head_second", 32'(rd_addr), 32'h4);
    chk("bp_sra_aluop", 32'(aluop), 32'h400);
    chk("bp_sra_shamt", imm, 32'h3);
    step();
    chk("bp_drained", 32'(out_valid), 32'h0);
    chk("bp_in_ready_back", 32'(in_ready), 32'h1);

    // Immediate extension
    send(32'h3041FFFF);
    chk("andi_imm", imm, 32'h0000FFFF);
    send(32'h2841FFFF);
    chk("slti_imm", imm, 32'hFFFFFFFF);
    send(32'h3C031234);
    chk("lui_imm", imm, 32'h12340000);
    chk("lui_aluop", 32'(aluop), 32'h800);

    // Illegal and NOP
    send(32'hFC000000);
    chk("illegal_flag", 32'(illegal), 32'h1);
    chk("illegal_aluop", 32'(aluop), 32'h0);
    send(32'h00000000);
    chk("nop_aluop", 32'(aluop), 32'h100);
    chk("nop_reg_write", 32'(reg_write), 32'h0);
    step();

    // Mixed stream with a stalling consumer; each wait is cycle-bounded
    for (int i = 0; i < 8; i++) begin
      int  n = 0;
      bit  took;
      in_valid = 1'b1;
      in_instr = vecs[i];
      do begin
        out_ready = ((i + n) % 3) != 0;
        took = in_ready;
        step();
        n++;
      end while (!took && n < 20);
      if (!took) chk("stream_accept_timeout", 32'h0, 32'h1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk("stream_drained", 32'(out_valid), 32'h0);

    // Flush with FIFO full and an op offered
    out_ready = 1'b0;
    send(32'h20090005);
    send(32'h3041FFFF);
    chk("flush_pre_full", 32'(in_ready), 32'h0);
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h3C031234;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    chk("flush_in_ready", 32'(in_ready), 32'h1);
    step();
    chk("flush_dropped", 32'(out_valid), 32'h0);

    // Asynchronous reset with two ops buffered
    send(32'h00221820);
    send(32'h000520C3);
    chk("rst_pre_valid", 32'(out_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'h0);
    chk("rst_async_aluop", 32'(aluop), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_release_valid", 32'(out_valid), 32'h0);
    chk("rst_release_ready", 32'(in_ready), 32'h1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
